mem_bist: RTL and testbench

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_bist.sv | 123 ++++++++++++
 tb/tb_mem_bist.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared defaults, state encoding and expected-data rule for the memory BIST.
package mem_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Computed at 32 bits so any DATA_W/ADDR_W up to 32 can truncate the result.
  function automatic logic [31:0] expected_word(input logic [31:0] pat,
                                                input logic        mode,
                                                input logic [31:0] addr);
    return mode ? (pat ^ addr) : pat;
  endfunction

endpackage

// File: rtl/mem_bist.sv
// Fill / read-back memory self-test: writes a seeded pattern, reads it back and
// reports mismatch count, lowest failing address and pass/fail.
module mem_bist
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   pat_q;
  logic                mode_q;
  logic                rd_valid;
  logic [ADDR_W-1:0]   rd_addr;
  logic                last;
  logic                accept;
  logic                mismatch;
  logic [ADDR_W:0]     err_nxt;
  logic [DATA_W-1:0]   exp_fill;
  logic [DATA_W-1:0]   exp_rd;

  assign last   = (cnt == ADDR_W'(DEPTH - 1));
  assign accept = (state == IDLE) && start;

  always_comb begin
    exp_fill = DATA_W'(expected_word(32'(pat_q), mode_q, 32'(cnt)));
    exp_rd   = DATA_W'(expected_word(32'(pat_q), mode_q, 32'(rd_addr)));
    mismatch = rd_valid && (mem_rdata != exp_rd);
    err_nxt  = err_cnt + (ADDR_W + 1)'(mismatch);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt;
        mem_wdata = exp_fill;
        if (last) state_nxt = READ;
      end
      READ: begin
        busy     = 1'b1;
        mem_addr = cnt;
        if (last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == FILL || state == READ) cnt <= last ? '0 : cnt + 1'b1;
      else                                cnt <= '0;
    end
  end

  // Read data arrives a cycle after its address, so the compare uses the
  // registered address; DRAIN exists only to cover the final word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q          <= '0;
      mode_q         <= 1'b0;
      rd_valid       <= 1'b0;
      rd_addr        <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      rd_valid <= (state == READ);
      rd_addr  <= cnt;
      if (accept) begin
        pat_q          <= pattern;
        mode_q         <= mode;
        err_cnt        <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
      end else begin
        if (mismatch) begin
          err_cnt <= err_nxt;
          if (err_cnt == '0) first_err_addr <= rd_addr;
        end
        if (state == DRAIN) pass <= (err_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist with a synchronous-read memory model and fault injection.
module tb_mem_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] pattern;
  logic       mode;
  logic       busy, done, pass;
  logic [5:0] err_cnt;
  logic [4:0] first_err_addr;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [9:0] mem_wdata;
  logic [9:0] mem_rdata;

  logic [9:0] mem [32];
  logic [9:0] rd_q;
  logic [4:0] ra_q;
  logic       corrupt_en = 1'b0;
  logic       zero_en    = 1'b0;

  int tests = 0;
  int fails = 0;
  int done_total = 0;
  int lat, ndone;
  logic       busy1;
  logic [9:0] wd9, wd31;

  always #5 clk = ~clk;

  mem_bist #(.ADDR_W(5), .DATA_W(10), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_q <= mem[mem_addr];
    ra_q <= mem_addr;
  end

  assign mem_rdata = zero_en ? 10'h000 :
                     (corrupt_en && (ra_q == 5'd9 || ra_q == 5'd31)) ? (rd_q ^ 10'h001) : rd_q;

  always @(negedge clk) if (done) done_total++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lat counts negedges after the accept edge, so cycle 1 is the first FILL cycle.
  task automatic run(input logic [9:0] pat, input logic md, input bit extra);
    @(negedge clk);
    start = 1'b1; pattern = pat; mode = md;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy1 = 1'b0; wd9 = '0; wd31 = '0;
    do begin
      @(negedge clk);
      lat++;
      start = extra && (lat == 10 || lat == 40);
      if (lat == 1)  busy1 = busy;
      if (lat == 10) wd9   = mem_wdata;
      if (lat == 32) wd31  = mem_wdata;
    end while (!done && lat < 200);
    start = 1'b0;
    ndone = 1;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; pattern = '0; mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_first", first_err_addr, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    // constant pattern, clean memory
    run(10'h155, 1'b0, 1'b0);
    check("c_latency", lat, 66);
    check("c_busy1", busy1, 1);
    check("c_wd9", wd9, 10'h155);
    check("c_pass", pass, 1);
    check("c_err", err_cnt, 0);
    check("c_first", first_err_addr, 0);
    check("c_idle_busy", busy, 0);
    check("c_idle_we", mem_we, 0);

    // address-xor pattern
    run(10'h3FF, 1'b1, 1'b0);
    check("x_wd9", wd9, 10'h3F6);
    check("x_wd31", wd31, 10'h3E0);
    check("x_mem9", mem[9], 10'h3F6);
    check("x_mem31", mem[31], 10'h3E0);
    check("x_pass", pass, 1);
    check("x_latency", lat, 66);

    // corrupted reads at 9 and 31
    corrupt_en = 1'b1;
    run(10'h3FF, 1'b1, 1'b0);
    corrupt_en = 1'b0;
    check("f_pass", pass, 0);
    check("f_err", err_cnt, 2);
    check("f_first", first_err_addr, 9);

    // stray starts while busy
    run(10'h155, 1'b0, 1'b1);
    check("s_latency", lat, 66);
    check("s_ndone", ndone, 1);
    check("s_pass", pass, 1);
    check("s_err", err_cnt, 0);
    check("s_idle_busy", busy, 0);

    // leave nonzero results behind, then abort mid-READ at address 12
    corrupt_en = 1'b1;
    run(10'h3FF, 1'b1, 1'b0);
    corrupt_en = 1'b0;
    @(negedge clk);
    start = 1'b1; pattern = 10'h2AA; mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (lat < 45);
    check("a_addr12", mem_addr, 12);
    check("a_we_read", mem_we, 0);
    d0 = done_total;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("a_busy", busy, 0);
    check("a_done", done, 0);
    check("a_pass", pass, 0);
    check("a_err", err_cnt, 0);
    check("a_first", first_err_addr, 0);
    check("a_addr", mem_addr, 0);
    check("a_wdata", mem_wdata, 0);
    repeat (5) @(negedge clk);
    check("a_nodone", done_total, d0);
    run(10'h0F0, 1'b1, 1'b0);
    check("a_rerun_lat", lat, 66);
    check("a_rerun_pass", pass, 1);

    // all-zero read data
    zero_en = 1'b1;
    run(10'h001, 1'b0, 1'b0);
    zero_en = 1'b0;
    check("z_err", err_cnt, 32);
    check("z_first", first_err_addr, 0);
    check("z_pass", pass, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
